// File: rtl/frame_pkg.sv
// Shared definitions for the 1011-sync serial link (transmitter and receiver).
package frame_pkg;

    // Transmit FSM phases, in line order
    typedef enum logic [2:0] {
        StIdle,
        StSync,
        StData,
        StParity,
        StGap
    } state_e;

    // Default sync pattern, sent MSB-first; the receiver hunts for the same value
    localparam int unsigned SyncWDefault = 4;
    localparam logic [SyncWDefault-1:0] SyncDefault = 4'b1011;

endpackage

// File: rtl/frame_tx_piso.sv
// Parallel-in/serial-out shift register. Holds {sync, payload} for one frame and
// shifts it out MSB-first, filling with zeros.
module frame_tx_piso #(
    parameter int unsigned W = 12
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic         shift_i,
    input  logic [W-1:0] data_i,
    // MSB as it will be after this edge; lets the owner register it in step
    output logic         msb_o
);

    logic [W-1:0] sh_q, sh_d;

    // Load has priority over shift
    always_comb begin
        sh_d = sh_q;
        if (load_i) begin
            sh_d = data_i;
        end else if (shift_i) begin
            sh_d = {sh_q[W-2:0], 1'b0};
        end
    end

    // Shift register state
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_q <= '0;
        end else begin
            sh_q <= sh_d;
        end
    end

    assign msb_o = sh_d[W-1];

endmodule

// File: rtl/frame_tx.sv
// Serial frame transmitter: sync, payload MSB-first, even parity, one gap bit.
// Accepts one payload word per frame over a valid/ready handshake.
module frame_tx
    import frame_pkg::*;
#(
    parameter int unsigned        DATA_W = 8,
    parameter int unsigned        SYNC_W = SyncWDefault,
    parameter logic [SYNC_W-1:0]  SYNC   = SyncDefault
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              out,
    output logic              out_valid,
    output logic              frame_done
);

    localparam int unsigned MaxW = (SYNC_W > DATA_W) ? SYNC_W : DATA_W;
    localparam int unsigned CntW = $clog2(MaxW);
    localparam int unsigned ShW  = SYNC_W + DATA_W;
    localparam logic [CntW-1:0] SyncLast = CntW'(SYNC_W - 1);
    localparam logic [CntW-1:0] DataLast = CntW'(DATA_W - 1);

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            parity_q, parity_d;
    logic            out_q, out_d;
    logic            out_valid_q, out_valid_d;
    logic            in_ready_q, in_ready_d;
    logic            frame_done_q, frame_done_d;

    logic            xfer;
    logic            sh_load;
    logic            sh_shift;
    logic            sh_msb;

    assign xfer = in_valid && in_ready_q;

    frame_tx_piso #(
        .W (ShW)
    ) u_piso (
        .clk     (clk),
        .rst     (rst),
        .load_i  (sh_load),
        .shift_i (sh_shift),
        .data_i  ({SYNC, in_data}),
        .msb_o   (sh_msb)
    );

    // Next state, counter, and registered-output values derived from the next state
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        parity_d = parity_q;
        sh_load  = 1'b0;
        sh_shift = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (xfer) begin
                    state_d = StSync;
                    cnt_d   = SyncLast;
                end
            end
            StSync: begin
                // Shift on the last sync bit too, bringing the payload MSB up
                sh_shift = 1'b1;
                if (cnt_q == '0) begin
                    state_d = StData;
                    cnt_d   = DataLast;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StData: begin
                if (cnt_q == '0) begin
                    state_d = StParity;
                    cnt_d   = '0;
                end else begin
                    sh_shift = 1'b1;
                    cnt_d    = cnt_q - 1'b1;
                end
            end
            StParity: begin
                state_d = StGap;
                cnt_d   = '0;
            end
            StGap: begin
                if (xfer) begin
                    state_d = StSync;
                    cnt_d   = SyncLast;
                end else begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase

        if (xfer) begin
            sh_load  = 1'b1;
            parity_d = ^in_data;
        end

        out_valid_d  = (state_d == StSync) || (state_d == StData) || (state_d == StParity);
        in_ready_d   = (state_d == StIdle) || (state_d == StGap);
        frame_done_d = (state_d == StGap);

        if ((state_d == StSync) || (state_d == StData)) begin
            out_d = sh_msb;
        end else if (state_d == StParity) begin
            out_d = parity_q;
        end else begin
            out_d = 1'b0;
        end
    end

    // State, counter, parity and output registers; reset drops any frame in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            parity_q     <= 1'b0;
            out_q        <= 1'b0;
            out_valid_q  <= 1'b0;
            in_ready_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            parity_q     <= parity_d;
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
            in_ready_q   <= in_ready_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign out        = out_q;
    assign out_valid  = out_valid_q;
    assign in_ready   = in_ready_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_frame_tx.sv
// Directed bench for frame_tx with a small 1011 detector on the serial line.
module tb_frame_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       out;
    logic       out_valid;
    logic       frame_done;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    frame_tx #(
        .DATA_W (8),
        .SYNC_W (4),
        .SYNC   (4'b1011)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out        (out),
        .out_valid  (out_valid),
        .frame_done (frame_done)
    );

    // Receiver-side 1011 hunter: registered hit one cycle after the last sync bit
    logic [3:0] hist_q;
    logic       det_q;
    always @(posedge clk) begin
        if (rst) begin
            hist_q <= 4'b0000;
            det_q  <= 1'b0;
        end else begin
            hist_q <= {hist_q[2:0], out};
            det_q  <= ({hist_q[2:0], out} == 4'b1011);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Present a word; returns in cycle 1 of the frame
    task automatic start(input logic [7:0] d);
        in_data  = d;
        in_valid = 1'b1;
        tick();
    endtask

    // Walk cycles 1..14 of a frame; drive in_valid with v_data during cycles v_from..v_to.
    // Returns in the gap cycle (14).
    task automatic expect_frame(input string name, input logic [13:0] exp, input int v_from,
                                input int v_to, input logic [7:0] v_data, input bit chk_det);
        for (int c = 1; c <= 14; c++) begin
            if (c >= v_from && c <= v_to) begin
                in_valid = 1'b1;
                in_data  = v_data;
            end else begin
                in_valid = 1'b0;
            end
            check($sformatf("%s c%0d out", name, c), out, exp[14-c]);
            check($sformatf("%s c%0d out_valid", name, c), out_valid, c <= 13);
            check($sformatf("%s c%0d frame_done", name, c), frame_done, c == 14);
            check($sformatf("%s c%0d in_ready", name, c), in_ready, c == 14);
            if (chk_det) check($sformatf("%s c%0d det", name, c), det_q, c == 5);
            if (c < 14) tick();
        end
    endtask

    task automatic expect_idle(input string name);
        check({name, " out"}, out, 1'b0);
        check({name, " out_valid"}, out_valid, 1'b0);
        check({name, " frame_done"}, frame_done, 1'b0);
        check({name, " in_ready"}, in_ready, 1'b1);
    endtask

    initial begin
        // Reset
        rst = 1'b1;
        tick();
        tick();
        check("rst out", out, 1'b0);
        check("rst out_valid", out_valid, 1'b0);
        check("rst in_ready", in_ready, 1'b0);
        check("rst frame_done", frame_done, 1'b0);
        rst = 1'b0;
        check("rel in_ready before edge", in_ready, 1'b0);
        tick();
        check("rel in_ready after edge", in_ready, 1'b1);

        // Single frame of A5: 1011 10100101 0 0
        start(8'hA5);
        expect_frame("A5", 14'b10111010010100, 0, -1, 8'h00, 1'b0);
        tick();
        expect_idle("A5 idle");

        // Parity one: 07 has three ones
        start(8'h07);
        expect_frame("07", 14'b10110000011110, 0, -1, 8'h00, 1'b0);
        tick();
        expect_idle("07 idle");

        // Parity zero, with the line looped into the detector
        start(8'h00);
        expect_frame("00", 14'b10110000000000, 0, -1, 8'h00, 1'b1);
        tick();
        expect_idle("00 idle");
        check("00 idle det", det_q, 1'b0);

        // Back-to-back: valid held with 3C after A5 is taken, transfer in the gap cycle
        start(8'hA5);
        expect_frame("b2b A5", 14'b10111010010100, 1, 14, 8'h3C, 1'b0);
        tick();
        expect_frame("b2b 3C", 14'b10110011110000, 0, -1, 8'h00, 1'b0);
        tick();
        expect_idle("b2b idle");

        // Stall: valid only in cycle 5 is ignored
        start(8'h55);
        expect_frame("stall 55", 14'b10110101010100, 5, 5, 8'hFF, 1'b0);
        tick();
        expect_idle("stall idle");

        // Valid held from cycle 5 is taken in the gap cycle
        start(8'h55);
        expect_frame("hold 55", 14'b10110101010100, 5, 14, 8'hC3, 1'b0);
        tick();
        expect_frame("hold C3", 14'b10111100001100, 0, -1, 8'h00, 1'b0);
        tick();
        expect_idle("hold idle");

        // Reset in cycle 7 of a frame
        start(8'h5A);
        in_valid = 1'b0;
        for (int c = 1; c < 7; c++) tick();
        check("mid c7 out_valid", out_valid, 1'b1);
        rst = 1'b1;
        tick();
        check("mid c8 out", out, 1'b0);
        check("mid c8 out_valid", out_valid, 1'b0);
        check("mid c8 in_ready", in_ready, 1'b0);
        check("mid c8 frame_done", frame_done, 1'b0);
        rst = 1'b0;
        tick();
        for (int c = 9; c <= 16; c++) begin
            expect_idle($sformatf("mid c%0d", c));
            tick();
        end

        // Link resumes after the mid-frame reset
        start(8'h07);
        expect_frame("post 07", 14'b10110000011110, 0, -1, 8'h00, 1'b0);
        tick();
        expect_idle("post idle");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
